// File: rtl/mat_row_bank.sv
// Shared SIZE x SIZE complex matrix store with round-robin read/write clients.
// Supports row and transposed (column) access on both ports; reads are read-before-write.
module mat_row_bank #(
  parameter  int SIZE   = 16,
  parameter  int WIDTH  = 64,
  parameter  int NUM_CH = 2,
  localparam int EW     = 2 * WIDTH,
  localparam int ROW_W  = SIZE * EW,
  localparam int AW     = $clog2(SIZE),
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        rd_req_i,
  input  logic [NUM_CH*AW-1:0]     rd_addr_i,
  input  logic [NUM_CH-1:0]        rd_col_i,
  output logic [NUM_CH-1:0]        rd_gnt_o,
  output logic [ROW_W-1:0]         rd_data_o,
  output logic [AW-1:0]            rd_addr_o,
  output logic                     rd_col_o,
  output logic [CW-1:0]            rd_ch_o,
  output logic                     rd_valid_o,
  input  logic [NUM_CH-1:0]        wr_req_i,
  input  logic [NUM_CH*AW-1:0]     wr_addr_i,
  input  logic [NUM_CH-1:0]        wr_col_i,
  input  logic [NUM_CH*ROW_W-1:0]  wr_data_i,
  output logic [NUM_CH-1:0]        wr_gnt_o,
  input  logic                     clear_i
);

  logic [ROW_W-1:0]  mem_q [SIZE];

  logic [CW-1:0]     rdPtr_q, rdPtr_d;
  logic [CW-1:0]     wrPtr_q, wrPtr_d;
  logic [ROW_W-1:0]  rdData_q;
  logic [AW-1:0]     rdAddr_q;
  logic              rdCol_q;
  logic [CW-1:0]     rdCh_q;
  logic              rdValid_q;

  int                rdIdx, wrIdx;
  logic              rdAny, wrAny;
  logic [NUM_CH-1:0] rdGnt, wrGnt;
  logic [CW-1:0]     rdSel;
  logic [AW-1:0]     rdAddr, wrAddr;
  logic              rdCol, wrCol;
  logic [ROW_W-1:0]  rdVec, wrVec;

  // Descending scan so the requester closest to ptr is the last (winning) assignment.
  function automatic int firstReq(input logic [NUM_CH-1:0] req, input logic [CW-1:0] ptr);
    int idx;
    firstReq = -1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[idx]) firstReq = idx;
    end
  endfunction

  always_comb begin
    rdIdx   = firstReq(rd_req_i, rdPtr_q);
    rdAny   = 1'b0;
    rdGnt   = '0;
    rdSel   = '0;
    rdAddr  = '0;
    rdCol   = 1'b0;
    rdPtr_d = rdPtr_q;
    if (rdIdx >= 0) begin
      rdAny        = 1'b1;
      rdGnt[rdIdx] = 1'b1;
      rdSel        = CW'(rdIdx);
      rdAddr       = rd_addr_i[rdIdx*AW +: AW];
      rdCol        = rd_col_i[rdIdx];
      rdPtr_d      = (rdIdx + 1 == NUM_CH) ? '0 : CW'(rdIdx + 1);
    end
  end

  always_comb begin
    wrIdx   = firstReq(wr_req_i, wrPtr_q);
    wrAny   = 1'b0;
    wrGnt   = '0;
    wrAddr  = '0;
    wrCol   = 1'b0;
    wrVec   = '0;
    wrPtr_d = wrPtr_q;
    if (wrIdx >= 0) begin
      wrAny        = 1'b1;
      wrGnt[wrIdx] = 1'b1;
      wrAddr       = wr_addr_i[wrIdx*AW +: AW];
      wrCol        = wr_col_i[wrIdx];
      wrVec        = wr_data_i[wrIdx*ROW_W +: ROW_W];
      wrPtr_d      = (wrIdx + 1 == NUM_CH) ? '0 : CW'(wrIdx + 1);
    end
  end

  // Out-of-range indices read back as zero.
  always_comb begin
    rdVec = '0;
    if (int'(rdAddr) < SIZE) begin
      if (rdCol) begin
        for (int r = 0; r < SIZE; r++)
          rdVec[r*EW +: EW] = mem_q[r][int'(rdAddr)*EW +: EW];
      end else begin
        rdVec = mem_q[rdAddr];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < SIZE; r++) mem_q[r] <= '0;
    end else if (clear_i) begin
      for (int r = 0; r < SIZE; r++) mem_q[r] <= '0;
    end else if (wrAny && (int'(wrAddr) < SIZE)) begin
      if (wrCol) begin
        for (int r = 0; r < SIZE; r++)
          mem_q[r][int'(wrAddr)*EW +: EW] <= wrVec[r*EW +: EW];
      end else begin
        mem_q[wrAddr] <= wrVec;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      rdData_q  <= '0;
      rdAddr_q  <= '0;
      rdCol_q   <= 1'b0;
      rdCh_q    <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      rdValid_q <= rdAny;
      if (rdAny) begin
        rdData_q <= rdVec;
        rdAddr_q <= rdAddr;
        rdCol_q  <= rdCol;
        rdCh_q   <= rdSel;
      end
    end
  end

  assign rd_gnt_o   = rdGnt;
  assign wr_gnt_o   = wrGnt;
  assign rd_data_o  = rdData_q;
  assign rd_addr_o  = rdAddr_q;
  assign rd_col_o   = rdCol_q;
  assign rd_ch_o    = rdCh_q;
  assign rd_valid_o = rdValid_q;

endmodule

// File: tb/tb_mat_row_bank.sv
// Directed bench for mat_row_bank: row/column access, round-robin order,
// read-before-write collisions, clear and reset behaviour.
module tb_mat_row_bank;

  localparam int SIZE  = 16;
  localparam int WIDTH = 64;
  localparam int NCH   = 2;
  localparam int EW    = 2 * WIDTH;
  localparam int ROW_W = SIZE * EW;
  localparam int AW    = 4;
  localparam int CW    = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     rd_req, rd_col, wr_req, wr_col;
  logic [NCH*AW-1:0]  rd_addr, wr_addr;
  logic [NCH*ROW_W-1:0] wr_data;
  logic               clear;
  logic [NCH-1:0]     rd_gnt, wr_gnt;
  logic [ROW_W-1:0]   rd_data;
  logic [AW-1:0]      rd_addr_o;
  logic               rd_col_o;
  logic [CW-1:0]      rd_ch;
  logic               rd_valid;

  int total = 0;
  int bad   = 0;

  logic [ROW_W-1:0] vecA, vecC, vecOne;
  logic [EW-1:0]    one;

  mat_row_bank #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_CH(NCH)) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_col_i(rd_col), .rd_gnt_o(rd_gnt),
    .rd_data_o(rd_data), .rd_addr_o(rd_addr_o), .rd_col_o(rd_col_o), .rd_ch_o(rd_ch),
    .rd_valid_o(rd_valid),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_col_i(wr_col), .wr_data_i(wr_data),
    .wr_gnt_o(wr_gnt), .clear_i(clear)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] rdReq, input logic [NCH*AW-1:0] rdAddr,
                               input logic [NCH-1:0] rdCol, input logic [NCH-1:0] wrReq,
                               input logic [NCH*AW-1:0] wrAddr, input logic [NCH-1:0] wrCol,
                               input logic clr);
    rd_req  = rdReq;
    rd_addr = rdAddr;
    rd_col  = rdCol;
    wr_req  = wrReq;
    wr_addr = wrAddr;
    wr_col  = wrCol;
    clear   = clr;
    #1;
  endtask

  function automatic logic [EW-1:0] elemOf(input logic [ROW_W-1:0] v, input int j);
    return v[j*EW +: EW];
  endfunction

  function automatic logic [EW-1:0] cplx(input real im, input real re);
    return {$realtobits(im), $realtobits(re)};
  endfunction

  initial begin
    for (int j = 0; j < SIZE; j++) begin
      vecA[j*EW +: EW] = cplx(real'(j), real'(100 + j));
      vecC[j*EW +: EW] = {64'd0, $realtobits(real'(j))};
    end
    one    = cplx(1.0, 1.0);
    vecOne = {SIZE{one}};

    rst     = 1'b1;
    wr_data = '0;
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    checkOutput("reset_valid", 128'(rd_valid), 128'd0);
    checkOutput("reset_data_zero", 128'(|rd_data), 128'd0);
    checkOutput("reset_meta", {rd_addr_o, rd_col_o, rd_ch}, 128'd0);
    checkOutput("idle_gnt", {rd_gnt, wr_gnt}, 128'd0);

    // Client 0 writes row 3, client 1 reads it back.
    wr_data[0 +: ROW_W] = vecA;
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b01, {4'd0, 4'd3}, 2'b00, 1'b0);
    checkOutput("wr_gnt_c0", 128'(wr_gnt), 128'(2'b01));
    tick;
    applyStimulus(2'b10, {4'd3, 4'd0}, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    checkOutput("rd_gnt_c1", 128'(rd_gnt), 128'(2'b10));
    tick;
    checkOutput("row3_valid", 128'(rd_valid), 128'd1);
    checkOutput("row3_meta", {rd_addr_o, rd_col_o, rd_ch}, {4'd3, 1'b0, 1'b1});
    checkOutput("row3_e5", elemOf(rd_data, 5), cplx(5.0, 105.0));
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    tick;
    checkOutput("idle_valid", 128'(rd_valid), 128'd0);
    checkOutput("hold_e5", elemOf(rd_data, 5), cplx(5.0, 105.0));

    // Column write of index 2 by client 1, then row and column readback.
    wr_data[ROW_W +: ROW_W] = vecC;
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b10, {4'd2, 4'd0}, 2'b10, 1'b0);
    checkOutput("wr_gnt_c1", 128'(wr_gnt), 128'(2'b10));
    tick;
    applyStimulus(2'b01, {4'd0, 4'd7}, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    tick;
    checkOutput("row7_e2", elemOf(rd_data, 2), {64'd0, $realtobits(7.0)});
    checkOutput("row7_e0", elemOf(rd_data, 0), 128'd0);
    applyStimulus(2'b01, {4'd0, 4'd2}, 2'b01, 2'b00, 8'h00, 2'b00, 1'b0);
    tick;
    checkOutput("col2_meta", {rd_addr_o, rd_col_o, rd_ch}, {4'd2, 1'b1, 1'b0});
    checkOutput("col2_e0", elemOf(rd_data, 0), {64'd0, $realtobits(0.0)});
    checkOutput("col2_e3", elemOf(rd_data, 3), {64'd0, $realtobits(3.0)});
    checkOutput("col2_e15", elemOf(rd_data, 15), {64'd0, $realtobits(15.0)});

    // Reset asserted mid-read clears outputs asynchronously.
    applyStimulus(2'b01, {4'd0, 4'd3}, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 128'(rd_valid), 128'd0);
    checkOutput("async_rst_data", 128'(|rd_data), 128'd0);
    tick;
    rst = 1'b0;
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    tick;
    checkOutput("post_rst_valid", 128'(rd_valid), 128'd0);

    // Both clients read continuously: grants alternate from pointer 0.
    applyStimulus(2'b11, {4'd2, 4'd3}, 2'b10, 2'b00, 8'h00, 2'b00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("rr_gnt%0d", i), 128'(rd_gnt), (i % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      tick;
      checkOutput($sformatf("rr_ch%0d", i), 128'(rd_ch), 128'(i % 2));
      checkOutput($sformatf("rr_zero%0d", i), 128'(|rd_data), 128'd0);
    end

    // Same-cycle write and read of row 4 returns the old contents.
    wr_data[0 +: ROW_W]     = vecA;
    wr_data[ROW_W +: ROW_W] = vecOne;
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b01, {4'd0, 4'd4}, 2'b00, 1'b0);
    tick;
    applyStimulus(2'b01, {4'd0, 4'd4}, 2'b00, 2'b10, {4'd4, 4'd0}, 2'b00, 1'b0);
    checkOutput("coll_wr_gnt", 128'(wr_gnt), 128'(2'b10));
    tick;
    checkOutput("coll_old_e5", elemOf(rd_data, 5), cplx(5.0, 105.0));
    applyStimulus(2'b01, {4'd0, 4'd4}, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    tick;
    checkOutput("coll_new_e5", elemOf(rd_data, 5), one);
    checkOutput("coll_new_e0", elemOf(rd_data, 0), one);

    // Clear beats a granted write; a read in the clear cycle sees pre-clear data.
    applyStimulus(2'b01, {4'd0, 4'd4}, 2'b00, 2'b01, {4'd0, 4'd0}, 2'b00, 1'b1);
    checkOutput("clr_wr_gnt", 128'(wr_gnt), 128'(2'b01));
    tick;
    checkOutput("clr_preclear_e7", elemOf(rd_data, 7), one);
    applyStimulus(2'b01, {4'd0, 4'd0}, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    tick;
    checkOutput("clr_row0", 128'(|rd_data), 128'd0);
    checkOutput("clr_row0_valid", 128'(rd_valid), 128'd1);
    applyStimulus(2'b01, {4'd0, 4'd15}, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    tick;
    checkOutput("clr_row15", 128'(|rd_data), 128'd0);
    applyStimulus(2'b01, {4'd0, 4'd4}, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    tick;
    checkOutput("clr_row4", 128'(|rd_data), 128'd0);
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b11, {4'd1, 4'd1}, 2'b00, 1'b0);
    checkOutput("clr_wrptr_adv", 128'(wr_gnt), 128'(2'b10));
    tick;
    applyStimulus(2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
